// File: rtl/gray_fifo_writer.sv
// Camera-side writer for the 8-bit grayscale pixel FIFO.
// Every frame that is started always produces exactly H*W writes, so the
// downstream reader can find frame boundaries by counting bytes. A frame
// damaged by FIFO back-pressure or by an early start-of-frame is padded out
// with PAD_VALUE, and the event is recorded in a saturating error counter.
module gray_fifo_writer #(
  parameter int         H         = 640,
  parameter int         W         = 480,
  parameter logic [7:0] PAD_VALUE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sof_i,
  input  logic        pix_valid_i,
  input  logic [7:0]  gray8_i,
  input  logic        fifo_full_i,
  output logic        fifo_wen_o,
  output logic [7:0]  fifo_wdata_o,
  output logic        frame_done_o,
  output logic        busy_o,
  output logic [15:0] err_frames_o,
  input  logic        clr_err_i
);

  localparam int                 CNT_W = $clog2(H * W);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(H * W - 1);

  typedef enum logic [1:0] {
    S_WAIT_SOF = 2'd0,
    S_STREAM   = 2'd1,
    S_PAD      = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_wen;
  logic [7:0]         r_wdata;
  logic               r_done;
  logic               r_busy;
  logic [15:0]        r_err;
  logic               w_err;
  logic               w_last;

  // Error counter saturates instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // One error per damaged frame: SOF lost to a full FIFO while idle, or the
  // STREAM->PAD transition (full and early SOF together still count once).
  assign w_err  = pix_valid_i &&
                  (((r_state == S_WAIT_SOF) && sof_i && fifo_full_i) ||
                   ((r_state == S_STREAM) && (fifo_full_i || sof_i)));
  assign w_last = (r_cnt == LAST);

  // Frame FSM with registered write port, done pulse and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT_SOF;
      r_cnt   <= '0;
      r_wen   <= 1'b0;
      r_wdata <= 8'h00;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_wen  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_WAIT_SOF: begin
          if (pix_valid_i && sof_i && !fifo_full_i) begin
            r_wen   <= 1'b1;
            r_wdata <= gray8_i;
            r_cnt   <= CNT_W'(1);
            r_state <= S_STREAM;
            r_busy  <= 1'b1;
          end
        end
        S_STREAM: begin
          if (pix_valid_i) begin
            if (fifo_full_i || sof_i) begin
              // Offending pixel is dropped; the rest of the frame is padded.
              r_state <= S_PAD;
            end else begin
              r_wen   <= 1'b1;
              r_wdata <= gray8_i;
              if (w_last) begin
                r_done  <= 1'b1;
                r_cnt   <= '0;
                r_state <= S_WAIT_SOF;
                r_busy  <= 1'b0;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
        end
        S_PAD: begin
          if (!fifo_full_i) begin
            r_wen   <= 1'b1;
            r_wdata <= PAD_VALUE;
            if (w_last) begin
              r_done  <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_WAIT_SOF;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_WAIT_SOF;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Damaged-frame counter; a clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 16'h0000;
    end else if (clr_err_i) begin
      r_err <= 16'h0000;
    end else if (w_err) begin
      r_err <= sat_inc(r_err);
    end
  end

  assign fifo_wen_o   = r_wen;
  assign fifo_wdata_o = r_wdata;
  assign frame_done_o = r_done;
  assign busy_o       = r_busy;
  assign err_frames_o = r_err;

endmodule

// File: tb/tb_gray_fifo_writer.sv
// Directed bench for gray_fifo_writer with a 4x2 frame.
module tb_gray_fifo_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sof_i, pix_valid_i, fifo_full_i, clr_err_i;
  logic [7:0]  gray8_i;
  logic        fifo_wen_o, frame_done_o, busy_o;
  logic [7:0]  fifo_wdata_o;
  logic [15:0] err_frames_o;

  int n_chk  = 0;
  int n_fail = 0;

  gray_fifo_writer #(.H(4), .W(2), .PAD_VALUE(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sof_i        (sof_i),
    .pix_valid_i  (pix_valid_i),
    .gray8_i      (gray8_i),
    .fifo_full_i  (fifo_full_i),
    .fifo_wen_o   (fifo_wen_o),
    .fifo_wdata_o (fifo_wdata_o),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o),
    .err_frames_o (err_frames_o),
    .clr_err_i    (clr_err_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sof;
    logic        vld;
    logic [7:0]  d;
    logic        full;
    logic        clr;
    logic        ewen;
    logic [7:0]  edata;
    logic        edone;
    logic        ebusy;
    logic [15:0] eerr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic sof, input logic vld, input logic [7:0] d,
                     input logic full, input logic clr, input logic ewen,
                     input logic [7:0] edata, input logic edone,
                     input logic ebusy, input logic [15:0] eerr);
    vec_t v;
    v.sof = sof; v.vld = vld; v.d = d; v.full = full; v.clr = clr;
    v.ewen = ewen; v.edata = edata; v.edone = edone; v.ebusy = ebusy;
    v.eerr = eerr;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic sof, input logic vld, input logic [7:0] d,
                       input logic full, input logic clr);
    sof_i = sof; pix_valid_i = vld; gray8_i = d;
    fifo_full_i = full; clr_err_i = clr;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // A normal intact 8-pixel frame starting at base, error count unchanged.
  task automatic add_frame(input logic [7:0] base, input logic [15:0] e);
    for (int i = 0; i < 8; i++)
      add(i == 0, 1'b1, 8'(base + i), 1'b0, 1'b0,
          1'b1, 8'(base + i), i == 7, i != 7, e);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0, 0);

    // Pixels before the first SOF are never written.
    for (int i = 0; i < 3; i++) add(0, 1, 8'hAA, 0, 0, 0, 8'h00, 0, 0, 16'd0);
    add_frame(8'h10, 16'd0);
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 16'd0);
    // Frame with an idle gap: the FSM holds, still busy.
    for (int i = 0; i < 8; i++) begin
      if (i == 2) add(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 16'd0);
      add(i == 0, 1, 8'(8'h20 + i), 0, 0, 1, 8'(8'h20 + i), i == 7, i != 7, 16'd0);
    end
    // FIFO full on the 4th pixel for 3 cycles, then 5 pad bytes.
    for (int i = 0; i < 3; i++)
      add(i == 0, 1, 8'(8'h30 + i), 0, 0, 1, 8'(8'h30 + i), 0, 1, 16'd0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 8'(8'h33 + i), 1, 0, 0, 8'h00, 0, 1, 16'd1);
    for (int i = 0; i < 5; i++)
      add(0, i < 2, 8'(8'h36 + i), 0, 0, 1, 8'h00, i == 4, i != 4, 16'd1);
    add_frame(8'h40, 16'd1);
    add(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 16'd0);
    // Early SOF after 5 pixels: 3 pad bytes, the new frame is skipped.
    for (int i = 0; i < 5; i++)
      add(i == 0, 1, 8'(8'h50 + i), 0, 0, 1, 8'(8'h50 + i), 0, 1, 16'd0);
    add(1, 1, 8'h60, 0, 0, 0, 8'h00, 0, 1, 16'd1);
    for (int i = 0; i < 3; i++)
      add(0, 1, 8'(8'h61 + i), 0, 0, 1, 8'h00, i == 2, i != 2, 16'd1);
    for (int i = 0; i < 4; i++)
      add(0, 1, 8'(8'h64 + i), 0, 0, 0, 8'h00, 0, 0, 16'd1);
    add_frame(8'h70, 16'd1);
    // SOF while full in WAIT_SOF: frame skipped entirely, one error.
    add(1, 1, 8'h80, 1, 0, 0, 8'h00, 0, 0, 16'd2);
    for (int i = 0; i < 7; i++)
      add(0, 1, 8'(8'h81 + i), 0, 0, 0, 8'h00, 0, 0, 16'd2);
    // Full and early SOF together count once; SOF during PAD is ignored.
    add(1, 1, 8'hA0, 0, 0, 1, 8'hA0, 0, 1, 16'd2);
    add(1, 1, 8'hA1, 1, 0, 0, 8'h00, 0, 1, 16'd3);
    for (int i = 0; i < 7; i++)
      add(i < 2, i < 2, 8'hB0, 0, 0, 1, 8'h00, i == 6, i != 6, 16'd3);
    // Clear in the same cycle as an error wins; next error counts from 0.
    add(1, 1, 8'h90, 1, 1, 0, 8'h00, 0, 0, 16'd0);
    add(1, 1, 8'h91, 1, 0, 0, 8'h00, 0, 0, 16'd1);

    // Reset state.
    cyc(); cyc();
    check("rst wen", 16'(fifo_wen_o), 16'd0);
    check("rst wdata", 16'(fifo_wdata_o), 16'd0);
    check("rst done", 16'(frame_done_o), 16'd0);
    check("rst busy", 16'(busy_o), 16'd0);
    check("rst err", err_frames_o, 16'd0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].sof, vq[i].vld, vq[i].d, vq[i].full, vq[i].clr);
      cyc();
      check($sformatf("vec%0d wen", i), 16'(fifo_wen_o), 16'(vq[i].ewen));
      if (vq[i].ewen)
        check($sformatf("vec%0d wdata", i), 16'(fifo_wdata_o), 16'(vq[i].edata));
      check($sformatf("vec%0d done", i), 16'(frame_done_o), 16'(vq[i].edone));
      check($sformatf("vec%0d busy", i), 16'(busy_o), 16'(vq[i].ebusy));
      check($sformatf("vec%0d err", i), err_frames_o, vq[i].eerr);
    end

    // Saturation of the error counter.
    drive(0, 0, 8'h00, 0, 1);
    cyc();
    check("sat clr", err_frames_o, 16'd0);
    drive(1, 1, 8'h00, 1, 0);
    repeat (65534) @(posedge clk);
    #1;
    check("sat fffe", err_frames_o, 16'hFFFE);
    cyc();
    check("sat ffff", err_frames_o, 16'hFFFF);
    cyc();
    check("sat hold", err_frames_o, 16'hFFFF);
    drive(0, 0, 8'h00, 0, 1);
    cyc();
    check("sat clr2", err_frames_o, 16'd0);

    // Reset in the middle of a frame: outputs drop at once, no padding.
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 1, 8'(8'hC0 + i), 0, 0);
      cyc();
      check("mid wen", 16'(fifo_wen_o), 16'd1);
      check("mid wdata", 16'(fifo_wdata_o), 16'(8'(8'hC0 + i)));
    end
    drive(1, 1, 8'h00, 1, 0);
    cyc();
    check("mid err pre", err_frames_o, 16'd1);
    drive(0, 1, 8'hC3, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst wen", 16'(fifo_wen_o), 16'd0);
    check("arst wdata", 16'(fifo_wdata_o), 16'd0);
    check("arst busy", 16'(busy_o), 16'd0);
    check("arst err", err_frames_o, 16'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8'(8'hD0 + i), 0, 0);
      cyc();
      check("post wen", 16'(fifo_wen_o), 16'd0);
      check("post busy", 16'(busy_o), 16'd0);
    end
    drive(1, 1, 8'hE0, 0, 0);
    cyc();
    check("post sof wen", 16'(fifo_wen_o), 16'd1);
    check("post sof data", 16'(fifo_wdata_o), 16'h00E0);
    check("post sof busy", 16'(busy_o), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_fifo_writer.md
Name: gray_fifo_writer

Overview:
Camera-side writer for the 8-bit grayscale pixel FIFO drained by the HDMI framebuffer path. Takes a raster pixel stream with a start-of-frame marker and writes exactly H*W bytes per frame into the FIFO. The downstream reader derives frame boundaries purely by counting, so this block guarantees frame-length integrity. On overflow or a truncated frame it pads the frame to full length with PAD_VALUE, drops the offending data and counts the error.

Parameters:
H, 640, pixels per line
W, 480, lines per frame
PAD_VALUE, 8'h00, byte written while padding a damaged frame
CNT_W, $clog2(H*W), pixel counter width (19 at default)

Ports:
clk  input  1  pixel-domain clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sof_i  input  1  first pixel of frame; qualified by pix_valid_i
pix_valid_i  input  1  gray8_i valid this cycle
gray8_i  input  8  grayscale pixel
fifo_full_i  input  1  FIFO programmable-full; must assert with at least 1 free entry remaining
fifo_wen_o  output  1  FIFO write enable, registered
fifo_wdata_o  output  8  FIFO write data, registered
frame_done_o  output  1  one-cycle pulse on the cycle the H*W-th byte of a frame is written
busy_o  output  1  high in STREAM or PAD
err_frames_o  output  16  saturating count of damaged or skipped frames
clr_err_i  input  1  synchronous clear of err_frames_o

Behaviour:
- Reset values: fifo_wen_o=0, fifo_wdata_o=0, frame_done_o=0, busy_o=0, err_frames_o=0, state=WAIT_SOF, cnt=0. Reset mid-frame abandons the frame without padding; the reader is reset by the same rst_n.
- Latency: a pixel accepted in cycle N appears on fifo_wen_o/fifo_wdata_o in cycle N+1. A "write" below means registering wen=1 plus data for the next cycle. This one-cycle latency is why fifo_full_i must be a programmable-full with a one-entry margin.
- cnt counts writes issued in the current frame. LAST = H*W-1. H*W >= 2 is required.
- WAIT_SOF:
  - pix_valid_i & sof_i & !fifo_full_i: write gray8_i, cnt=1, go to STREAM.
  - pix_valid_i & sof_i & fifo_full_i: increment err_frames_o, stay in WAIT_SOF. The whole frame is skipped because nothing was written for it.
  - All other pixels are ignored.
- STREAM:
  - pix_valid_i & !sof_i & !fifo_full_i: write gray8_i.
    - If cnt==LAST: frame_done_o=1 (aligned with that write), cnt=0, go to WAIT_SOF.
    - Otherwise cnt++.
  - pix_valid_i & fifo_full_i: drop the pixel, increment err_frames_o, go to PAD.
  - pix_valid_i & sof_i (early SOF, short frame): increment err_frames_o, go to PAD. The new frame is skipped and its pixel is not written.
  - !pix_valid_i: hold.
- PAD:
  - Each cycle with !fifo_full_i: write PAD_VALUE. On cnt==LAST, pulse frame_done_o and go to WAIT_SOF; otherwise cnt++.
  - fifo_full_i: stall.
  - All input pixels, including sof_i, are ignored.
- Simultaneous events: fifo_full_i together with early sof_i counts as one error. A STREAM-to-PAD transition counts exactly one error per frame.
- Error counter: saturates at 16'hFFFF. clr_err_i has priority over an increment in the same cycle.
- busy_o is registered and reflects the state after the transition.

Decomposition:
- No shared package. The state encoding (WAIT_SOF, STREAM, PAD) is local parameters.
- CNT_W and LAST are local parameters derived from H and W.
- No sub-module needed. The saturating error counter stays inline.

Test Plan:
- H=4, W=2, FIFO never full; frame of 8 pixels 0x10..0x17 with sof on the first -> 8 writes of 0x10..0x17, each one cycle after input; frame_done_o pulses with the 0x17 write; err_frames_o=0.
- Pixels before the first sof (0xAA x3), then a valid frame -> the 0xAA bytes are never written; exactly 8 writes follow.
- fifo_full_i asserted when the 4th pixel arrives, released 3 cycles later -> 3 pixel writes; err_frames_o=1; then 5 bytes of PAD_VALUE; frame_done_o on the 8th write; next sof frame is written normally.
- Early sof after 5 pixels -> err_frames_o=1; 3 pad bytes; that new frame is skipped; the following sof frame is written intact.
- sof arriving while fifo_full_i=1 in WAIT_SOF -> zero writes for that frame; err_frames_o increments by exactly 1.
- Force err_frames_o to 0xFFFF with an error event -> holds 0xFFFF.
- clr_err_i in the same cycle as an error -> err_frames_o=0.
- rst_n low mid-STREAM -> all outputs 0 immediately; no pad bytes written.
